// File: rtl/fixed_ln_pkg.sv
// ln_pkg: shared definitions for the fixed-point natural-logarithm unit.
//   state_t  : controller states (IDLE, NORM, SERIES, DONE)
//   LN2      : ln(2) scaled by 2^16, rounded to nearest
//   ln2_fix  : ln(2) scaled by 2^frac, rounded to nearest
//   recip    : round(2^frac / i), used to build the series coefficient table
package ln_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      NORM   = 2'd1,
      SERIES = 2'd2,
      DONE   = 2'd3
   } state_t;

   // round(ln2 * 2^32); narrower scalings are derived from it with rounding
   localparam longint unsigned LN2_Q32 = 64'd2977044472;

   function automatic int unsigned ln2_fix(input int unsigned frac);
      longint unsigned v;
      v = (LN2_Q32 + (64'd1 << (31 - frac))) >> (32 - frac);
      return 32'(v);
   endfunction

   localparam int unsigned LN2 = ln2_fix(16);

   // Round-half-up division; only evaluated on constants at elaboration.
   function automatic int unsigned recip(input int unsigned i, input int unsigned frac);
      if (i == 0) return 0;
      return ((32'd1 << frac) + i / 2) / i;
   endfunction

endpackage

// File: rtl/fixed_ln_if.sv
// fixed_ln_if: operand/result handshake bundle for fixed_ln.
//   in_valid / in_ready / x_in      : operand channel, unsigned Q(W-FRAC).FRAC
//   out_valid / out_ready / ln_out  : result channel, signed Q(W-FRAC).FRAC
//   err                             : operand was zero, valid with out_valid
// master drives operands and accepts results; slave is the ln unit.
interface fixed_ln_if #(
   parameter int unsigned W = 32
) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] ln_out;
   logic         err;

   modport master (
      output in_valid, x_in, out_ready,
      input  in_ready, out_valid, ln_out, err
   );

   modport slave (
      input  in_valid, x_in, out_ready,
      output in_ready, out_valid, ln_out, err
   );
endinterface

// File: rtl/fixed_ln_lod.sv
// ln_lod: combinational leading-one detector.
//   x    : W-bit input
//   msb  : index of the highest set bit (0 when x is zero)
//   zero : x has no bits set
module ln_lod #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0]         x,
   output logic [$clog2(W)-1:0] msb,
   output logic                 zero
);
   localparam int unsigned PW = $clog2(W);

   always_comb begin
      msb  = '0;
      zero = (x == '0);
      // Ascending scan: the last set bit seen is the most significant.
      for (int unsigned b = 0; b < W; b++) begin
         if (x[b]) msb = b[PW-1:0];
      end
   end
endmodule

// File: rtl/fixed_ln.sv
// fixed_ln: sequential fixed-point natural logarithm.
//   clk, rst : clock and synchronous active-high reset
//   bus      : fixed_ln_if slave (operand in, signed result + err out)
// The operand is range-reduced to m*2^k with m in [0.75,1.5), then
// ln(1+u), u = m-1, is summed one series term per clock and k*ln2 is added.
module fixed_ln
   import ln_pkg::*;
#(
   parameter int unsigned W       = 32,
   parameter int unsigned FRAC    = 16,
   parameter int unsigned N_TERMS = 12
) (
   input logic        clk,
   input logic        rst,
   fixed_ln_if.slave  bus
);
   localparam int unsigned PW    = $clog2(W);
   localparam int unsigned KW    = PW + 1;
   localparam int unsigned UW    = FRAC + 2;
   localparam int unsigned PRW   = 2 * UW;
   localparam int unsigned IW    = $clog2(N_TERMS + 1);
   localparam int unsigned LN2_Q = ln2_fix(FRAC);
   localparam logic signed [UW-1:0] ONE = UW'(1 << FRAC);

   state_t               state;
   logic                 out_v;
   logic [W-1:0]         x_r;
   logic signed [KW-1:0] k_r;
   logic signed [UW-1:0] u_r;
   logic signed [UW-1:0] pw_r;
   logic signed [W-1:0]  sum_r;
   logic [IW-1:0]        i_r;
   logic [W-1:0]         ln_r;
   logic                 err_r;

   // Coefficient table, constant-folded at elaboration.
   logic [UW-1:0] recip_tab [0:N_TERMS];
   for (genvar g = 0; g <= N_TERMS; g++) begin : g_recip
      assign recip_tab[g] = UW'(recip(g, FRAC));
   end

   // Normalisation
   logic [PW-1:0]        msb;
   logic                 zero;
   logic [FRAC:0]        m_sh;
   logic [FRAC:0]        m_f;
   logic signed [KW-1:0] k_n;
   logic signed [UW-1:0] u_n;

   ln_lod #(.W(W)) u_lod (
      .x    (x_r),
      .msb  (msb),
      .zero (zero)
   );

   always_comb begin
      k_n = $signed({1'b0, msb}) - $signed(KW'(FRAC));
      if (msb >= PW'(FRAC)) m_sh = (FRAC+1)'(x_r >> (msb - PW'(FRAC)));
      else                  m_sh = (FRAC+1)'(x_r << (PW'(FRAC) - msb));
      // m >= 1.5: halve it and bump the exponent so |u| stays small.
      m_f = m_sh;
      if (m_sh[FRAC-1]) begin
         m_f = m_sh >> 1;
         k_n = k_n + KW'(1);
      end
      u_n = $signed(UW'(m_f)) - ONE;
   end

   // Series step
   logic signed [PRW-1:0] term_prod;
   logic signed [PRW-1:0] pow_prod;
   logic signed [UW-1:0]  term;
   logic signed [UW-1:0]  pw_n;
   logic signed [W-1:0]   sum_n;
   logic signed [W-1:0]   k_ln2;

   always_comb begin
      term_prod = PRW'(pw_r) * PRW'($signed(recip_tab[i_r]));
      pow_prod  = PRW'(pw_r) * PRW'(u_r);
      term      = UW'(term_prod >>> FRAC);
      pw_n      = UW'(pow_prod >>> FRAC);
      sum_n     = i_r[0] ? sum_r + W'(term) : sum_r - W'(term);
      k_ln2     = W'(k_r) * $signed(W'(LN2_Q));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out_v <= 1'b0;
         x_r   <= '0;
         k_r   <= '0;
         u_r   <= '0;
         pw_r  <= '0;
         sum_r <= '0;
         i_r   <= '0;
         ln_r  <= '0;
         err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_r   <= bus.x_in;
                  state <= NORM;
               end
            end
            NORM: begin
               if (zero) begin
                  ln_r  <= {1'b1, {(W-1){1'b0}}};
                  err_r <= 1'b1;
                  state <= DONE;
               end else begin
                  k_r   <= k_n;
                  u_r   <= u_n;
                  pw_r  <= u_n;
                  sum_r <= '0;
                  i_r   <= IW'(1);
                  state <= SERIES;
               end
            end
            SERIES: begin
               sum_r <= sum_n;
               pw_r  <= pw_n;
               i_r   <= i_r + IW'(1);
               if (i_r == IW'(N_TERMS)) begin
                  ln_r  <= sum_n + k_ln2;
                  err_r <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               // out_valid rises one cycle after entering DONE, so the
               // result register has settled before it is presented.
               if (!out_v) begin
                  out_v <= 1'b1;
               end else if (bus.out_ready) begin
                  out_v <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_v;
   assign bus.ln_out    = ln_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_fixed_ln.sv
// tb_fixed_ln: self-checking bench for fixed_ln, checked against an
// ideal real-valued natural log and exact k*ln2 values for powers of two.
module tb_fixed_ln;
   localparam int unsigned W       = 32;
   localparam int unsigned FRAC    = 16;
   localparam int unsigned N_TERMS = 12;
   localparam int          LAT     = N_TERMS + 2;
   localparam int          LN2_LSB = 45426;
   localparam real         TOL     = 16.0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fixed_ln_if #(.W(W)) bus ();

   fixed_ln #(.W(W), .FRAC(FRAC), .N_TERMS(N_TERMS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   function automatic real ideal_ln(input logic [31:0] x);
      return $ln(real'(x) / 65536.0) * 65536.0;
   endfunction

   function automatic bit is_pow2(input logic [31:0] x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

   function automatic int log2_of(input logic [31:0] x);
      int r = 0;
      for (int b = 0; b < 32; b++) if (x[b]) r = b;
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [31:0] x, output logic [31:0] res,
                       output logic e, output int lat);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_ready: in_ready=%b required 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.x_in     = x;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bus.ln_out;
      e   = bus.err;
   endtask

   task automatic take();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_checks++;
      if (bus.ln_out !== 32'h0) begin n_fail++; $display("FAIL reset_ln_out: got %h want 0", bus.ln_out); end
      n_checks++;
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_exact();
      logic [31:0] xs [4] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_0001};
      logic [31:0] res;
      logic        e;
      int          lat;
      int          expv;
      foreach (xs[j]) begin
         expv = (log2_of(xs[j]) - 16) * LN2_LSB;
         send(xs[j], res, e, lat);
         n_checks++;
         if (lat != LAT) begin n_fail++; $display("FAIL exact_latency x=%h: got %0d want %0d", xs[j], lat, LAT); end
         n_checks++;
         if ($signed(res) !== expv) begin n_fail++; $display("FAIL exact_value x=%h: got %0d want %0d", xs[j], $signed(res), expv); end
         n_checks++;
         if (e !== 1'b0) begin n_fail++; $display("FAIL exact_err x=%h: got %b want 0", xs[j], e); end
         take();
      end
   endtask

   task automatic test_approx();
      logic [31:0] xs  [2] = '{32'h0002_B7E1, 32'h0003_0000};
      int          tgt [2] = '{65536, 71998};
      logic [31:0] res;
      logic        e;
      int          lat;
      int          d;
      foreach (xs[j]) begin
         send(xs[j], res, e, lat);
         d = $signed(res) - tgt[j];
         if (d < 0) d = -d;
         n_checks++;
         if (lat != LAT) begin n_fail++; $display("FAIL approx_latency x=%h: got %0d want %0d", xs[j], lat, LAT); end
         n_checks++;
         if (d > 16) begin n_fail++; $display("FAIL approx_value x=%h: got %0d want %0d+-16", xs[j], $signed(res), tgt[j]); end
         n_checks++;
         if (e !== 1'b0) begin n_fail++; $display("FAIL approx_err x=%h: got %b want 0", xs[j], e); end
         take();
      end
   endtask

   task automatic test_zero();
      logic [31:0] res;
      logic        e;
      int          lat;
      send(32'h0, res, e, lat);
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", lat); end
      n_checks++;
      if (e !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %b want 1", e); end
      n_checks++;
      if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL zero_value: got %h want 80000000", res); end
      take();
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      logic        e;
      int          lat;
      send(32'h0002_0000, res, e, lat);
      n_checks++;
      if ($signed(res) !== LN2_LSB) begin n_fail++; $display("FAIL bp_value: got %0d want %0d", $signed(res), LN2_LSB); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.in_valid = (c % 2 == 0);
         bus.x_in     = 32'h0003_0000;
         @(posedge clk); #1;
         n_checks++;
         if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c=%0d: got %b want 1", c, bus.out_valid); end
         n_checks++;
         if ($signed(bus.ln_out) !== LN2_LSB || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold_data c=%0d: got %0d/%b want %0d/0", c, $signed(bus.ln_out), bus.err, LN2_LSB);
         end
         n_checks++;
         if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, bus.in_ready); end
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_not_queued: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] res;
      logic        e;
      int          lat;
      bit          spurious = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_in     = 32'h0003_0000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.x_in     = 32'h0002_0000;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      n_checks++;
      if (bus.ln_out !== 32'h0 || bus.err !== 1'b0) begin
         n_fail++; $display("FAIL rst_outputs: got %h/%b want 0/0", bus.ln_out, bus.err);
      end
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      for (int c = 0; c < LAT + 4; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) spurious = 1'b1;
      end
      n_checks++;
      if (spurious) begin n_fail++; $display("FAIL rst_dropped: operand survived reset, got activity want idle"); end
      send(32'h0002_0000, res, e, lat);
      n_checks++;
      if ($signed(res) !== LN2_LSB || lat != LAT) begin
         n_fail++; $display("FAIL rst_next_op: got %0d lat %0d want %0d lat %0d", $signed(res), lat, LN2_LSB, LAT);
      end
      take();
   endtask

   task automatic test_random();
      logic [31:0] x;
      logic [31:0] res;
      logic        e;
      int          lat;
      real         d;
      for (int n = 0; n < 30; n++) begin
         if (n % 4 == 3) x = 32'h1 << $urandom_range(0, 31);
         else            x = $urandom >> $urandom_range(0, 31);
         if (x == 0) x = 32'h1;
         send(x, res, e, lat);
         n_checks++;
         if (lat != LAT || e !== 1'b0) begin
            n_fail++; $display("FAIL rand_timing x=%h: lat %0d err %b want %0d/0", x, lat, e, LAT);
         end
         if (is_pow2(x)) begin
            n_checks++;
            if ($signed(res) !== (log2_of(x) - 16) * LN2_LSB) begin
               n_fail++; $display("FAIL rand_pow2 x=%h: got %0d want %0d", x, $signed(res), (log2_of(x) - 16) * LN2_LSB);
            end
         end else begin
            d = real'($signed(res)) - ideal_ln(x);
            if (d < 0.0) d = -d;
            n_checks++;
            if (d > TOL) begin
               n_fail++; $display("FAIL rand_value x=%h: got %0d want %f+-16", x, $signed(res), ideal_ln(x));
            end
         end
         take();
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.x_in      = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_exact();
      test_approx();
      test_zero();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
